// File: rtl/wb_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_loader
// Description : Packs a byte stream little-endian into 32-bit words and
//               writes them over a Wishbone B4 pipelined bus at incrementing
//               addresses. It reports progress, completion, bus errors and
//               timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_loader #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [31:0]      adr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    input  logic             wb_stall_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_o
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Timeout fires on the last permitted WAIT cycle so that exactly TIMEOUT
    // WAIT cycles elapse before the bus is released.
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REQ     = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_adr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_words;
    logic [31:0]        r_dat;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_wb_adr;
    logic [31:0]        r_wb_dat;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_done;
    logic               r_err;

    logic               w_start_ok;
    logic               w_byte_fire;
    logic               w_last_byte;
    logic               w_req_acc;
    logic               w_fail;
    logic               w_ack_ok;
    logic               w_last_word;
    logic               w_timeout;

    // State register; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_byte_fire = 1'b0;
        w_last_byte = 1'b0;
        w_req_acc   = 1'b0;
        w_fail      = 1'b0;
        w_ack_ok    = 1'b0;
        w_last_word = 1'b0;
        w_timeout   = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start_ok = 1'b1;
                    if (len_i != '0) w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_byte_fire = byte_valid_i;
                if (byte_valid_i && (r_byte_cnt == 2'd3)) begin
                    w_last_byte = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!wb_stall_i) begin
                    w_req_acc   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Error (or timeout) wins over a simultaneous ack.
                if (wb_err_i || w_timeout) begin
                    w_fail      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (wb_ack_i) begin
                    w_ack_ok    = 1'b1;
                    w_last_word = ((r_words + 1'b1) == r_len);
                    w_state_nxt = w_last_word ? S_IDLE : S_COLLECT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: address, length, progress, status flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_adr   <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_adr   <= {adr_i[31:2], 2'b00};
                r_len   <= len_i;
                r_words <= '0;
                r_err   <= 1'b0;
                r_done  <= (len_i == '0);
            end
            if (w_ack_ok) begin
                r_adr   <= r_adr + 32'd4;
                r_words <= r_words + 1'b1;
                r_done  <= w_last_word;
            end
            if (w_fail) r_err <= 1'b1;
        end
    end

    // Byte packing into the word buffer; lane 0 receives the first byte.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_dat      <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (w_start_ok) r_byte_cnt <= '0;
            if (w_byte_fire) begin
                r_dat[{r_byte_cnt, 3'b000} +: 8] <= byte_data_i;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // Bus address/data captured once per word so they stay frozen while
    // stalled and hold their last value after the cycle ends.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wb_adr <= '0;
            r_wb_dat <= '0;
        end else if (w_last_byte) begin
            r_wb_adr <= r_adr;
            r_wb_dat <= {byte_data_i, r_dat[23:0]};
        end
    end

    // Response timeout counter; zero in the first WAIT cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)               r_tmo_cnt <= '0;
        else if (w_req_acc)         r_tmo_cnt <= '0;
        else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign byte_ready_o = (r_state == S_COLLECT);
    assign wb_cyc_o     = (r_state == S_REQ) || (r_state == S_WAIT);
    assign wb_stb_o     = (r_state == S_REQ);
    assign wb_we_o      = wb_cyc_o;
    assign wb_sel_o     = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_adr_o     = r_wb_adr;
    assign wb_dat_o     = r_wb_dat;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign words_o      = r_words;

endmodule
`default_nettype wire
